// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART byte transmitter
//
// Purpose: grants NUM_REQ requesters access to a single byte transmitter in
// round-robin order, sequences start/busy/done, inserts an inter-frame gap
// and flags a transmitter that never accepts a start.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   req       per-requester send request (level)
//   req_data  byte of requester i on bits [8i+7:8i]
//   ack       one-cycle pulse when requester's byte has finished on the line
//   tx_start  one-cycle start strobe to the transmitter
//   tx_data   byte to transmit, held from tx_start until done
//   tx_busy   transmitter busy, high while a frame is on the line
//   grant_id  index of current/last granted requester
//   active    high in any state other than IDLE
//   err       one-cycle pulse on start timeout
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [2:0]           grant_id,
    output logic                 active,
    output logic                 err
);

    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int TO_EFF  = (START_TIMEOUT < 1) ? 1 : START_TIMEOUT;
    localparam logic [15:0] GAP_LAST = 16'(GAP_EFF - 1);
    localparam logic [15:0] TO_LAST  = 16'(TO_EFF - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t        state;
    logic [IW-1:0] last;   // last served requester; search starts just after it
    logic [IW-1:0] cur;    // requester owning the frame in flight
    logic [15:0]   tcnt;
    logic [15:0]   gcnt;

    logic [7:0]    bytes [NUM_REQ];
    logic [IW-1:0] pick;
    logic          found;
    int            idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign bytes[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Rotating priority search: first asserted request after 'last', wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(last) + 1 + i) % NUM_REQ;
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last     <= IW'(NUM_REQ - 1);
            cur      <= '0;
            tcnt     <= '0;
            gcnt     <= '0;
            ack      <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            grant_id <= 3'd0;
            active   <= 1'b0;
            err      <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            tx_start <= 1'b0;
            ack      <= '0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        tx_data  <= bytes[pick];
                        grant_id <= 3'(pick);
                        cur      <= pick;
                        tx_start <= 1'b1;
                        active   <= 1'b1;
                        tcnt     <= '0;
                        state    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // Busy already high in the strobe cycle counts as accepted.
                    if (tx_busy) begin
                        tcnt  <= '0;
                        state <= WAIT_DONE;
                    end else if (tcnt == TO_LAST) begin
                        // Faulty requester still loses priority so others progress.
                        err   <= 1'b1;
                        last  <= cur;
                        tcnt  <= '0;
                        gcnt  <= '0;
                        state <= GAP;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        ack[cur] <= 1'b1;
                        last     <= cur;
                        gcnt     <= '0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    if (gcnt == GAP_LAST) begin
                        gcnt   <= '0;
                        active <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gcnt <= gcnt + 16'd1;
                    end
                end
                default: begin
                    active <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [2:0]  grant_id;
    logic        active;
    logic        err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .GAP_CYCLES(16),
        .START_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .active(active),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req_v;
        logic [31:0] data;
        logic [2:0]  exp_g;
        logic [7:0]  exp_d;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transmitter model: waits for tx_start, holds busy for busy_len cycles,
    // returns granted id, byte and the ack seen one cycle after busy falls.
    task automatic do_frame(input int busy_len, output logic [2:0] g,
                            output logic [7:0] d, output logic [3:0] a);
        int n;
        bit stable;
        n = 0;
        while (tx_start !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("tx_start_seen", 32'(tx_start), 1);
        g = grant_id;
        d = tx_data;
        tx_busy = 1'b1;
        stable = 1'b1;
        @(negedge clk);
        chk("tx_start_one_cycle", 32'(tx_start), 0);
        for (int i = 1; i < busy_len; i++) begin
            if (tx_data !== d) stable = 1'b0;
            @(negedge clk);
        end
        if (tx_data !== d) stable = 1'b0;
        tx_busy = 1'b0;
        @(negedge clk);
        a = ack;
        if (tx_data !== d) stable = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", 32'(ack), 0);
        chk("tx_data_stable", 32'(stable), 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] g;
        logic [7:0] d;
        logic [3:0] a;
        int n;
        int first_low;
        bit saw_ack;

        tbl[0]  = '{4'b1111, 32'h13121110, 3'd0, 8'h10};
        tbl[1]  = '{4'b1110, 32'h13121110, 3'd1, 8'h11};
        tbl[2]  = '{4'b1100, 32'h13121110, 3'd2, 8'h12};
        tbl[3]  = '{4'b1000, 32'h13121110, 3'd3, 8'h13};
        tbl[4]  = '{4'b0010, 32'h23222120, 3'd1, 8'h21};
        tbl[5]  = '{4'b0110, 32'h23222120, 3'd2, 8'h22};
        tbl[6]  = '{4'b0010, 32'h23222120, 3'd1, 8'h21};
        tbl[7]  = '{4'b1001, 32'h33323130, 3'd3, 8'h33};
        tbl[8]  = '{4'b1001, 32'h34323130, 3'd0, 8'h30};
        tbl[9]  = '{4'b1000, 32'h34323130, 3'd3, 8'h34};
        tbl[10] = '{4'b0010, 32'h43424140, 3'd1, 8'h41};
        tbl[11] = '{4'b1111, 32'h43424140, 3'd2, 8'h42};
        tbl[12] = '{4'b1011, 32'h43424140, 3'd3, 8'h43};
        tbl[13] = '{4'b0011, 32'h43424140, 3'd0, 8'h40};
        tbl[14] = '{4'b0010, 32'h43424140, 3'd1, 8'h41};

        reset = 1'b0;
        req = 4'b0000;
        req_data = 32'h0;
        tx_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_err", 32'(err), 0);
        reset = 1'b1;
        @(negedge clk);

        // Single byte, long busy, gap timing.
        req = 4'b0001;
        req_data = 32'h00000041;
        @(negedge clk);
        chk("t1_tx_start", 32'(tx_start), 1);
        chk("t1_tx_data", 32'(tx_data), 'h41);
        chk("t1_grant", 32'(grant_id), 0);
        chk("t1_active", 32'(active), 1);
        tx_busy = 1'b1;
        @(negedge clk);
        chk("t1_tx_start_drop", 32'(tx_start), 0);
        repeat (99) @(negedge clk);
        tx_busy = 1'b0;
        @(negedge clk);
        chk("t1_ack", 32'(ack), 'b0001);
        req_data = 32'h00000042;
        n = 0;
        first_low = -1;
        while (tx_start !== 1'b1 && n < 40) begin
            if (active !== 1'b1 && first_low < 0) first_low = n;
            @(negedge clk);
            n++;
        end
        chk("t1_gap_active_cycles", 32'(first_low), 16);
        chk("t1_ack_to_next_start", 32'(n), 17);
        do_frame(5, g, d, a);
        chk("t1b_grant", 32'(g), 0);
        chk("t1b_data", 32'(d), 'h42);
        chk("t1b_ack", 32'(a), 'b0001);
        req = 4'b0000;

        // Round-robin vector table, starting from reset priority.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            req = tbl[i].req_v;
            req_data = tbl[i].data;
            do_frame(1 + (i % 4), g, d, a);
            chk($sformatf("v%0d_grant", i), 32'(g), 32'(tbl[i].exp_g));
            chk($sformatf("v%0d_data", i), 32'(d), 32'(tbl[i].exp_d));
            chk($sformatf("v%0d_ack", i), 32'(a), 32'(4'b0001 << tbl[i].exp_g));
        end
        req = 4'b0000;

        // Start timeout: busy never rises.
        req = 4'b0001;
        req_data = 32'h0000615A;
        n = 0;
        while (tx_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_start_seen", 32'(tx_start), 1);
        chk("to_grant", 32'(grant_id), 0);
        saw_ack = 1'b0;
        n = 0;
        while (err !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
            if (ack !== 4'b0000) saw_ack = 1'b1;
        end
        chk("to_err_latency", 32'(n), 8);
        @(negedge clk);
        chk("to_err_one_cycle", 32'(err), 0);
        n = 0;
        while (active !== 1'b0 && n < 50) begin
            if (ack !== 4'b0000) saw_ack = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("to_gap_len", 32'(n), 15);
        chk("to_no_ack", 32'(saw_ack), 0);
        req = 4'b0011;
        do_frame(3, g, d, a);
        chk("to_next_grant", 32'(g), 1);
        chk("to_next_data", 32'(d), 'h61);
        chk("to_next_ack", 32'(a), 'b0010);
        req = 4'b0001;
        do_frame(2, g, d, a);
        chk("to_retry_grant", 32'(g), 0);
        chk("to_retry_data", 32'(d), 'h5A);
        chk("to_retry_ack", 32'(a), 'b0001);
        req = 4'b0000;

        // Data changes and req drops after grant.
        req = 4'b0001;
        req_data = 32'h00000055;
        n = 0;
        while (tx_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("dc_grant", 32'(grant_id), 0);
        chk("dc_data", 32'(tx_data), 'h55);
        req = 4'b0000;
        req_data = 32'hAAAAAAAA;
        tx_busy = 1'b1;
        saw_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_data !== 8'h55) saw_ack = 1'b0;
        end
        chk("dc_data_held", 32'(saw_ack), 1);
        tx_busy = 1'b0;
        @(negedge clk);
        chk("dc_ack", 32'(ack), 'b0001);
        chk("dc_data_at_ack", 32'(tx_data), 'h55);

        // Reset in WAIT_DONE.
        req = 4'b0010;
        req_data = 32'h00007788;
        n = 0;
        while (tx_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rs_grant", 32'(grant_id), 1);
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rs_active_before", 32'(active), 1);
        reset = 1'b0;
        #1;
        chk("rs_tx_data", 32'(tx_data), 0);
        chk("rs_grant_id", 32'(grant_id), 0);
        chk("rs_active", 32'(active), 0);
        chk("rs_ack", 32'(ack), 0);
        chk("rs_tx_start", 32'(tx_start), 0);
        chk("rs_err", 32'(err), 0);
        tx_busy = 1'b0;
        saw_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack !== 4'b0000) saw_ack = 1'b1;
        end
        chk("rs_no_ack", 32'(saw_ack), 0);
        reset = 1'b1;
        req = 4'b0011;
        do_frame(2, g, d, a);
        chk("rs_prio_grant", 32'(g), 0);
        chk("rs_prio_data", 32'(d), 'h88);
        chk("rs_prio_ack", 32'(a), 'b0001);
        req = 4'b0010;
        do_frame(2, g, d, a);
        chk("rs_next_grant", 32'(g), 1);
        chk("rs_next_data", 32'(d), 'h77);
        chk("rs_next_ack", 32'(a), 'b0010);
        req = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
